// File: rtl/spi_pkg.sv
// Shared SPI definitions for the controller and responder sides of the link.
// Contents:
//   SPI_CPOL, SPI_CPHA  link mode (mode 0)
//   SPI_DATA_WIDTH      default word width shared with the controller
//   spi_resp_state_t    responder FSM states
package spi_pkg;

  localparam int unsigned SPI_CPOL       = 0;
  localparam int unsigned SPI_CPHA       = 0;
  localparam int unsigned SPI_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    WAIT_CS,
    IDLE,
    ACTIVE
  } spi_resp_state_t;

endpackage

// File: rtl/spi_evt_counter.sv
// Event counter that wraps after MAX_COUNT events.
// Ports:
//   clk_in       system clock
//   rst_in       synchronous active-high reset (count and pulse cleared)
//   evt_in       count enable, one event per cycle
//   hit_max_out  registered pulse, high the cycle after the MAX_COUNT-th event
module spi_evt_counter #(
  parameter int unsigned MAX_COUNT = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic evt_in,
  output logic hit_max_out
);

  localparam int unsigned CntW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

  logic [CntW-1:0] count_q, count_d;
  logic            hit_q, hit_d;

  always_comb begin
    count_d = count_q;
    hit_d   = 1'b0;
    if (evt_in) begin
      if (count_q == CntW'(MAX_COUNT - 1)) begin
        count_d = '0;
        hit_d   = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      hit_q   <= hit_d;
    end
  end

  assign hit_max_out = hit_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder, oversampling SCLK/CS_N/COPI in the clk_in domain.
// Ports:
//   clk_in, rst_in            system clock, synchronous active-high reset
//   sclk_in, cs_n_in, copi_in raw asynchronous SPI inputs
//   cipo_out                  responder data out, 0 while not selected
//   tx_data_in, tx_valid_in   write into the one-entry TX holding buffer
//   tx_ready_out              TX holding buffer empty
//   rx_data_out, rx_valid_out last complete received word and its update pulse
//   busy_out                  frame in progress
//   underrun_out              pulse: word load found the TX buffer empty
module spi_responder
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sclk_in,
  input  logic                  cs_n_in,
  input  logic                  copi_in,
  output logic                  cipo_out,
  input  logic [DATA_WIDTH-1:0] tx_data_in,
  input  logic                  tx_valid_in,
  output logic                  tx_ready_out,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid_out,
  output logic                  busy_out,
  output logic                  underrun_out
);

  // Input synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_n_sync_q, copi_sync_q, primed_q;
  logic                   sclk_prev_q, cs_n_prev_q;
  logic                   sclk_s, cs_n_s, copi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sclk_sync_q <= '0;
      cs_n_sync_q <= '1;
      copi_sync_q <= '0;
      primed_q    <= '0;
      sclk_prev_q <= 1'b0;
      cs_n_prev_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
      cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], cs_n_in};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_in};
      primed_q    <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_s;
      cs_n_prev_q <= cs_n_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_n_s & cs_n_prev_q;
  assign cs_rise   = cs_n_s & ~cs_n_prev_q;

  // State and datapath
  spi_resp_state_t       state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] txbuf_q, txbuf_d, rx_data_q, rx_data_d;
  logic                  txbuf_full_q, txbuf_full_d;
  logic                  cipo_q, cipo_d, bnd_q, bnd_d;
  logic                  rx_valid_q, underrun_q, underrun_d;
  logic                  load, sample_en, hit_max;

  spi_evt_counter #(
    .MAX_COUNT(DATA_WIDTH)
  ) u_bit_cnt (
    .clk_in     (clk_in),
    .rst_in     (rst_in | cs_rise),
    .evt_in     (sample_en),
    .hit_max_out(hit_max)
  );

  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    cipo_d     = cipo_q;
    bnd_d      = bnd_q;
    load       = 1'b0;
    sample_en  = 1'b0;

    unique case (state_q)
      WAIT_CS: begin
        cipo_d = 1'b0;
        bnd_d  = 1'b0;
        // primed_q keeps the reset value of the cs_n synchroniser from reading as a deselect
        if (primed_q[SYNC_STAGES-1] && cs_n_s) state_d = IDLE;
      end
      IDLE: begin
        cipo_d = 1'b0;
        bnd_d  = 1'b0;
        if (cs_fall) begin
          state_d   = ACTIVE;
          load      = 1'b1;
          sample_en = sclk_rise;  // load first, then sample
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          cipo_d  = 1'b0;
          bnd_d   = 1'b0;
        end else begin
          sample_en = sclk_rise;
          if (hit_max) bnd_d = 1'b1;
          if (sclk_fall) begin
            if (bnd_q) begin
              load  = 1'b1;
              bnd_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
              cipo_d     = tx_shift_q[DATA_WIDTH-2];
            end
          end
        end
      end
      default: state_d = WAIT_CS;
    endcase

    if (load) begin
      tx_shift_d = txbuf_full_q ? txbuf_q : '0;
      cipo_d     = txbuf_full_q & txbuf_q[DATA_WIDTH-1];
    end
    if (sample_en) rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], copi_s};

    underrun_d = load & ~txbuf_full_q;

    // A load frees a full buffer; a write is only taken while the buffer is empty
    txbuf_d      = txbuf_q;
    txbuf_full_d = txbuf_full_q;
    if (load && txbuf_full_q) txbuf_full_d = 1'b0;
    if (tx_valid_in && !txbuf_full_q) begin
      txbuf_d      = tx_data_in;
      txbuf_full_d = 1'b1;
    end

    // Completion is independent of state so a cs_rise right after the last bit keeps the word
    rx_data_d = hit_max ? rx_shift_q : rx_data_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= WAIT_CS;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      txbuf_q      <= '0;
      txbuf_full_q <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      cipo_q       <= 1'b0;
      bnd_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      txbuf_q      <= txbuf_d;
      txbuf_full_q <= txbuf_full_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= hit_max;
      cipo_q       <= cipo_d;
      bnd_q        <= bnd_d;
      underrun_q   <= underrun_d;
    end
  end

  assign cipo_out     = cipo_q;
  assign tx_ready_out = ~txbuf_full_q;
  assign rx_data_out  = rx_data_q;
  assign rx_valid_out = rx_valid_q;
  assign busy_out     = (state_q == ACTIVE);
  assign underrun_out = underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
module tb_spi_responder;

  logic       clk = 1'b0;
  logic       rst_in, sclk_in, cs_n_in, copi_in, cipo_out;
  logic [7:0] tx_data_in, rx_data_out;
  logic       tx_valid_in, tx_ready_out, rx_valid_out, busy_out, underrun_out;

  always #5 clk = ~clk;

  spi_responder #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .sclk_in     (sclk_in),
    .cs_n_in     (cs_n_in),
    .copi_in     (copi_in),
    .cipo_out    (cipo_out),
    .tx_data_in  (tx_data_in),
    .tx_valid_in (tx_valid_in),
    .tx_ready_out(tx_ready_out),
    .rx_data_out (rx_data_out),
    .rx_valid_out(rx_valid_out),
    .busy_out    (busy_out),
    .underrun_out(underrun_out)
  );

  int         vec = 0;
  int         mis = 0;
  logic [7:0] tx_q[$];    // words local logic will hand to the TX buffer, in order
  logic [7:0] rx_got[$];  // words seen with rx_valid_out
  int         un_cnt = 0;
  int         rdy_falls = 0;
  logic       rdy_prev = 1'b1;
  logic       busy_mid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Local-logic model: write the next queued word whenever the buffer reports ready
  initial begin
    tx_valid_in = 1'b0;
    tx_data_in  = '0;
    forever begin
      @(negedge clk);
      tx_valid_in = 1'b0;
      if (!rst_in && tx_ready_out && tx_q.size() > 0) begin
        tx_data_in  = tx_q.pop_front();
        tx_valid_in = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rx_valid_out) rx_got.push_back(rx_data_out);
      if (underrun_out) un_cnt++;
      if (rdy_prev && !tx_ready_out) rdy_falls++;
      rdy_prev = tx_ready_out;
    end
  end

  // SPI controller: n words MSB first; CIPO captured just before each falling edge.
  // cs_n rises together with the last fall (or the stop_after-th fall for an abort).
  task automatic run_frame(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                           input int n, input int half, input int stop_after,
                           output logic [23:0] got);
    logic [7:0] w[3];
    int         k;
    bit         done;
    w[0] = w0;
    w[1] = w1;
    w[2] = w2;
    k    = 0;
    done = 1'b0;
    got  = '0;
    cs_n_in = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        if (!done) begin
          copi_in = w[i][b];
          repeat (half) @(negedge clk);
          sclk_in = 1'b1;
          repeat (half) @(negedge clk);
          got = {got[22:0], cipo_out};
          k++;
          if (k == 1) busy_mid = busy_out;
          sclk_in = 1'b0;
          if (k == n * 8 || k == stop_after) begin
            cs_n_in = 1'b1;
            done    = 1'b1;
          end
        end
      end
    end
    copi_in = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] copi;
    logic [7:0] txw;
    bit         preload;
    logic [7:0] exp_rx;
    logic [7:0] exp_cipo;
    int         exp_un;
  } vec_t;

  vec_t        tbl[4];
  logic [23:0] got;
  logic [7:0]  w[2];
  logic [7:0]  t[2];
  int          un0, n;

  initial begin
    tbl[0] = '{8'hA5, 8'h3C, 1'b1, 8'hA5, 8'h3C, 0};
    tbl[1] = '{8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF, 0};
    tbl[2] = '{8'hFF, 8'h81, 1'b1, 8'hFF, 8'h81, 0};
    tbl[3] = '{8'h5A, 8'h00, 1'b0, 8'h5A, 8'h00, 1};

    rst_in  = 1'b1;
    sclk_in = 1'b0;
    cs_n_in = 1'b1;
    copi_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cipo", 32'(cipo_out), 32'd0);
    check("reset tx_ready", 32'(tx_ready_out), 32'd1);
    check("reset rx_data", 32'(rx_data_out), 32'd0);
    check("reset rx_valid", 32'(rx_valid_out), 32'd0);
    check("reset busy", 32'(busy_out), 32'd0);
    check("reset underrun", 32'(underrun_out), 32'd0);
    rst_in = 1'b0;
    repeat (6) @(negedge clk);

    // Single-word frames at 10 MHz SCLK
    foreach (tbl[i]) begin
      un0 = un_cnt;
      rx_got.delete();
      if (tbl[i].preload) tx_q.push_back(tbl[i].txw);
      run_frame(tbl[i].copi, 8'h00, 8'h00, 1, 5, 0, got);
      check("tbl rx count", 32'(rx_got.size()), 32'd1);
      check("tbl rx_data", 32'(rx_data_out), 32'(tbl[i].exp_rx));
      check("tbl cipo word", 32'(got[7:0]), 32'(tbl[i].exp_cipo));
      check("tbl underruns", 32'(un_cnt - un0), 32'(tbl[i].exp_un));
    end

    // Abort after 5 rises: no word, previous rx_data kept
    rx_got.delete();
    run_frame(8'hFF, 8'h00, 8'h00, 1, 5, 5, got);
    check("abort rx count", 32'(rx_got.size()), 32'd0);
    check("abort rx_data held", 32'(rx_data_out), 32'h5A);
    tx_q.push_back(8'h69);
    run_frame(8'hC3, 8'h00, 8'h00, 1, 5, 0, got);
    check("post-abort rx count", 32'(rx_got.size()), 32'd1);
    check("post-abort rx_data", 32'(rx_data_out), 32'hC3);
    check("post-abort cipo", 32'(got[7:0]), 32'h69);
    check("busy in frame", 32'(busy_mid), 32'd1);

    // Three back-to-back words with refills
    rx_got.delete();
    un0       = un_cnt;
    rdy_falls = 0;
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    tx_q.push_back(8'h33);
    run_frame(8'h01, 8'hFF, 8'h80, 3, 5, 0, got);
    check("b2b rx count", 32'(rx_got.size()), 32'd3);
    if (rx_got.size() == 3) begin
      check("b2b rx0", 32'(rx_got[0]), 32'h01);
      check("b2b rx1", 32'(rx_got[1]), 32'hFF);
      check("b2b rx2", 32'(rx_got[2]), 32'h80);
    end
    check("b2b cipo0", 32'(got[23:16]), 32'h11);
    check("b2b cipo1", 32'(got[15:8]), 32'h22);
    check("b2b cipo2", 32'(got[7:0]), 32'h33);
    check("b2b ready falls", 32'(rdy_falls), 32'd3);
    check("b2b underruns", 32'(un_cnt - un0), 32'd0);

    // Reset mid-frame with cs_n held low: rest of the frame ignored
    rx_got.delete();
    cs_n_in = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 7; b >= 0; b--) begin
      if (b == 4) begin
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
      end
      copi_in = b[0];
      repeat (5) @(negedge clk);
      sclk_in = 1'b1;
      repeat (5) @(negedge clk);
      if (b < 4) check("busy after reset", 32'(busy_out), 32'd0);
      sclk_in = 1'b0;
      if (b == 0) cs_n_in = 1'b1;
    end
    repeat (8) @(negedge clk);
    check("reset frame rx count", 32'(rx_got.size()), 32'd0);
    tx_q.push_back(8'h5C);
    run_frame(8'h3A, 8'h00, 8'h00, 1, 5, 0, got);
    check("post-reset rx count", 32'(rx_got.size()), 32'd1);
    check("post-reset rx_data", 32'(rx_data_out), 32'h3A);
    check("post-reset cipo", 32'(got[7:0]), 32'h5C);

    // Random frames with SCLK at clk/4
    un0 = un_cnt;
    for (int f = 0; f < 1000; f++) begin
      n = int'($urandom_range(1, 2));
      for (int i = 0; i < 2; i++) begin
        w[i] = 8'($urandom);
        t[i] = 8'($urandom);
        if (i < n) tx_q.push_back(t[i]);
      end
      rx_got.delete();
      run_frame(w[0], w[1], 8'h00, n, 2, 0, got);
      check("rnd rx count", 32'(rx_got.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
        if (rx_got.size() > i) check("rnd rx word", 32'(rx_got[i]), 32'(w[i]));
        check("rnd cipo word", 32'(got[(n - 1 - i) * 8 +: 8]), 32'(t[i]));
      end
    end
    check("rnd underruns", 32'(un_cnt - un0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
